// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blank guard intervals and
// frame-synchronous display updates. All display outputs are registered.
module seven_seg_scan_ctrl #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    output logic [6:0]  cat,
    output logic        dp,
    output logic [3:0]  anode,
    output logic        upd_pending,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      disp, pend;
    logic             commit;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0:    font = 7'b1000000;
            4'h1:    font = 7'b1111001;
            4'h2:    font = 7'b0100100;
            4'h3:    font = 7'b0110000;
            4'h4:    font = 7'b0011001;
            4'h5:    font = 7'b0010010;
            4'h6:    font = 7'b0000010;
            4'h7:    font = 7'b1111000;
            4'h8:    font = 7'b0000000;
            4'h9:    font = 7'b0010000;
            4'hA:    font = 7'b0001000;
            4'hB:    font = 7'b0000011;
            4'hC:    font = 7'b1000110;
            4'hD:    font = 7'b0100001;
            4'hE:    font = 7'b0000110;
            default: font = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == DIGIT_LAST) begin
                        state_nxt = BLANK;
                        idx_nxt   = idx + 1'b1;
                        cnt_nxt   = '0;
                        commit    = (idx == 2'd3);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they line up with the state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            disp        <= 16'h0000;
            pend        <= 16'h0000;
            upd_pending <= 1'b0;
            frame_done  <= 1'b0;
            anode       <= 4'b1111;
            cat         <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            frame_done <= commit;

            if (state == IDLE && load) begin
                disp        <= data_in;
                pend        <= data_in;
                upd_pending <= 1'b0;
            end else if (commit) begin
                disp        <= load ? data_in : pend;
                upd_pending <= 1'b0;
                if (load) pend <= data_in;
            end else if (load) begin
                pend        <= data_in;
                upd_pending <= 1'b1;
            end

            if (state_nxt == DRIVE) begin
                anode <= ~(4'b0001 << idx_nxt);
                cat   <= blank_mask[idx_nxt] ? 7'b1111111 : font(disp[{idx_nxt, 2'b00} +: 4]);
                dp    <= blank_mask[idx_nxt] | ~dp_in[idx_nxt];
            end else begin
                anode <= 4'b1111;
                cat   <= 7'b1111111;
                dp    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a frame-position model predicts the
// outputs after every rising edge; predictions are compared on the falling edge.
module tb_seven_seg_scan_ctrl;

    localparam int DIGIT = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DIGIT + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [6:0]  cat;
    logic        dp;
    logic [3:0]  anode;
    logic        upd_pending;
    logic        frame_done;

    seven_seg_scan_ctrl #(.DIGIT_CYCLES(DIGIT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .load(load),
        .dp_in(dp_in), .blank_mask(blank_mask), .cat(cat), .dp(dp), .anode(anode),
        .upd_pending(upd_pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] cat;
        logic       dp;
        logic       upd;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [6:0] font_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: m_t is the position inside the frame; digit = m_t / SLOT, dark while m_t % SLOT < BLANK.
    bit          m_active;
    int          m_t;
    logic [15:0] m_disp, m_pend;
    bit          m_pending;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        bit   was_idle;
        bit   commit;
        int   dig;
        commit = 1'b0;
        if (!rst_n) begin
            m_active  = 1'b0;
            m_t       = 0;
            m_disp    = 16'h0;
            m_pend    = 16'h0;
            m_pending = 1'b0;
        end else begin
            was_idle = !m_active;
            commit   = m_active && en && (m_t == FRAME - 1);
            if (!en) begin
                m_active = 1'b0;
                m_t      = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_t      = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            if (was_idle && load) begin
                m_disp    = data_in;
                m_pend    = data_in;
                m_pending = 1'b0;
            end else if (commit) begin
                if (load) m_pend = data_in;
                m_disp    = m_pend;
                m_pending = 1'b0;
            end else if (load) begin
                m_pend    = data_in;
                m_pending = 1'b1;
            end
        end
        e.anode = 4'hF;
        e.cat   = 7'h7F;
        e.dp    = 1'b1;
        e.upd   = m_pending;
        e.fd    = commit;
        if (m_active && (m_t % SLOT) >= BLANK) begin
            dig     = m_t / SLOT;
            e.anode = ~(4'b0001 << dig);
            if (!blank_mask[dig]) begin
                e.cat = font_tab[m_disp[dig*4 +: 4]];
                e.dp  = ~dp_in[dig];
            end
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("anode", 16'(anode), 16'(e.anode));
            check("cat", 16'(cat), 16'(e.cat));
            check("dp", 16'(dp), 16'(e.dp));
            check("upd_pending", 16'(upd_pending), 16'(e.upd));
            check("frame_done", 16'(frame_done), 16'(e.fd));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] d);
        data_in = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Waits (bounded) until the model sits at frame position tgt.
    task automatic wait_t(input int tgt);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (m_active && m_t == tgt) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wait_frame_pos", 16'(found), 16'd1);
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_anode"}, 16'(anode), 16'hF);
        check({tag, "_cat"}, 16'(cat), 16'h7F);
        check({tag, "_dp"}, 16'(dp), 16'd1);
        check({tag, "_upd"}, 16'(upd_pending), 16'd0);
        check({tag, "_fd"}, 16'(frame_done), 16'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_dark("async_reset");
        tick(3);

        // Load in IDLE commits immediately; first frame shows 1234.
        rst_n = 1'b1;
        en    = 1'b1;
        pulse_load(16'h1234);
        tick(FRAME + 4);

        // Mid-frame load waits for the frame boundary.
        wait_t(5);
        pulse_load(16'hABCD);
        tick(2 * FRAME);

        // Two loads in one frame: last wins; then a load on the commit edge.
        wait_t(3);
        pulse_load(16'h1111);
        tick(3);
        pulse_load(16'h2222);
        wait_t(FRAME - 1);
        pulse_load(16'h3333);
        tick(FRAME + 2);

        // Live per-digit blanking and decimal points.
        blank_mask = 4'b1010;
        dp_in      = 4'b0001;
        tick(FRAME + 3);
        blank_mask = 4'b0000;
        dp_in      = 4'b0110;
        tick(FRAME);
        dp_in      = 4'b0000;

        // Disable during DRIVE of digit 2, then restart from BLANK digit 0.
        wait_t(2 * SLOT + BLANK + 1);
        en = 1'b0;
        tick(4);
        en = 1'b1;
        tick(SLOT + 2);

        // Reset mid-DRIVE with an update pending.
        pulse_load(16'h5A5A);
        wait_t(SLOT + BLANK + 1);
        check("pending_before_reset", 16'(upd_pending), 16'd1);
        #2 rst_n = 1'b0;
        #1 check_dark("mid_drive_reset");
        @(negedge clk);
        tick(1);
        rst_n = 1'b1;
        tick(FRAME + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
